// File: rtl/alu_reg_pkg.sv
// Shared definitions for the register-file/ALU sequencer.
//   state_t    : sequencer FSM encoding
//   *_LSB/_W   : control-word field positions and widths
//   CTRL_MASK  : keeps W_Addr, R_Addr_A, R_Addr_B and ALU_OP, zeroes the rest
package alu_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam int unsigned WADDR_LSB   = 0;
    localparam int unsigned RADDR_A_LSB = 10;
    localparam int unsigned RADDR_B_LSB = 20;
    localparam int unsigned ALUOP_LSB   = 28;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned ALUOP_W     = 4;

    localparam logic [31:0] CTRL_MASK = 32'hF1F07C1F;

endpackage

// File: rtl/alu_reg_seq_ctrl.sv
// Multi-cycle sequencer driving the register-file/ALU datapath control word.
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   instr/instr_valid : instruction word and its valid strobe
//   instr_ready       : high only in IDLE
//   ctrl_word         : masked instruction held from DECODE until next accept
//   Write_Reg         : one-cycle register-file write enable (in WB)
//   ZF, OF            : ALU flags from the datapath
//   zf_q, of_q        : flags captured at the end of WB
//   done              : one-cycle retire pulse (first IDLE cycle after WB)
//   busy              : state != IDLE
//   retired_cnt       : wrapping count of retired instructions
import alu_reg_pkg::*;

module alu_reg_seq_ctrl #(
    parameter int unsigned EXEC_CYCLES = 2,
    parameter bit          SUPPRESS_R0 = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [31:0]      ctrl_word,
    output logic             Write_Reg,
    input  logic             ZF,
    input  logic             OF,
    output logic             zf_q,
    output logic             of_q,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_exec_cnt;
    logic [31:0]      r_ctrl_word;
    logic             r_write_reg;
    logic             r_zf;
    logic             r_of;
    logic             r_done;
    logic [CNT_W-1:0] r_retired_cnt;
    logic             w_exec_last;
    logic             w_wr_en;

    assign w_exec_last = (r_exec_cnt == EXEC_LAST);
    assign w_wr_en     = !(SUPPRESS_R0 && (r_ctrl_word[WADDR_LSB +: ADDR_W] == '0));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (instr_valid) w_state_nxt = DECODE;
            DECODE:  w_state_nxt = EXEC;
            EXEC:    if (w_exec_last) w_state_nxt = WB;
            WB:      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = (r_state == IDLE);
        busy        = (r_state != IDLE);
        ctrl_word   = r_ctrl_word;
        Write_Reg   = r_write_reg;
        zf_q        = r_zf;
        of_q        = r_of;
        done        = r_done;
        retired_cnt = r_retired_cnt;
    end

    // Registered datapath controls. Write_Reg is set on the EXEC->WB edge so
    // it is high exactly during WB; done is set on the WB->IDLE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_word   <= '0;
            r_exec_cnt    <= '0;
            r_write_reg   <= 1'b0;
            r_zf          <= 1'b0;
            r_of          <= 1'b0;
            r_done        <= 1'b0;
            r_retired_cnt <= '0;
        end else begin
            r_write_reg <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (instr_valid) r_ctrl_word <= instr & CTRL_MASK;
                end
                DECODE: begin
                    r_exec_cnt <= '0;
                end
                EXEC: begin
                    r_exec_cnt <= r_exec_cnt + 4'd1;
                    if (w_exec_last) r_write_reg <= w_wr_en;
                end
                WB: begin
                    // Flags are the pre-write values; the register file
                    // updates on this same edge.
                    r_zf          <= ZF;
                    r_of          <= OF;
                    r_retired_cnt <= r_retired_cnt + CNT_W'(1);
                    r_done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_reg_seq_ctrl.sv
// Directed bench for alu_reg_seq_ctrl with a behavioural register-file/ALU.
import alu_reg_pkg::*;

module tb_alu_reg_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;

    // main DUT (defaults)
    logic        d_ready, d_wr, d_zf, d_of, d_done, d_busy;
    logic [31:0] d_ctrl;
    logic [15:0] d_cnt;
    // SUPPRESS_R0 = 0
    logic        n_ready, n_wr, n_zf, n_of, n_done, n_busy;
    logic [31:0] n_ctrl;
    logic [15:0] n_cnt;
    // CNT_W = 2
    logic        q_ready, q_wr, q_zf, q_of, q_done, q_busy;
    logic [31:0] q_ctrl;
    logic [1:0]  q_cnt;

    // behavioural datapath
    logic [31:0] rf [32];
    logic        tb_we;
    logic [4:0]  tb_wa;
    logic [31:0] tb_wd;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_op;
    logic        alu_zf, alu_of;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    alu_reg_seq_ctrl u_dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(d_ready), .ctrl_word(d_ctrl), .Write_Reg(d_wr),
        .ZF(alu_zf), .OF(alu_of), .zf_q(d_zf), .of_q(d_of),
        .done(d_done), .busy(d_busy), .retired_cnt(d_cnt)
    );

    alu_reg_seq_ctrl #(.SUPPRESS_R0(1'b0)) u_dut_nr0 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(n_ready), .ctrl_word(n_ctrl), .Write_Reg(n_wr),
        .ZF(alu_zf), .OF(alu_of), .zf_q(n_zf), .of_q(n_of),
        .done(n_done), .busy(n_busy), .retired_cnt(n_cnt)
    );

    alu_reg_seq_ctrl #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(q_ready), .ctrl_word(q_ctrl), .Write_Reg(q_wr),
        .ZF(alu_zf), .OF(alu_of), .zf_q(q_zf), .of_q(q_of),
        .done(q_done), .busy(q_busy), .retired_cnt(q_cnt)
    );

    always_comb begin
        alu_a  = rf[d_ctrl[RADDR_A_LSB +: ADDR_W]];
        alu_b  = rf[d_ctrl[RADDR_B_LSB +: ADDR_W]];
        alu_op = d_ctrl[ALUOP_LSB +: ALUOP_W];
        case (alu_op)
            4'h1:    alu_y = alu_a + alu_b;
            4'h2:    alu_y = alu_a - alu_b;
            default: alu_y = '0;
        endcase
        alu_zf = (alu_y == 32'd0);
        alu_of = (alu_op == 4'h1) && (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
    end

    always @(posedge clk) begin
        if (tb_we)     rf[tb_wa] <= tb_wd;
        else if (d_wr) rf[d_ctrl[WADDR_LSB +: ADDR_W]] <= alu_y;
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rb,
                                       input logic [4:0] ra, input logic [4:0] rw);
        logic [31:0] v;
        v = '0;
        v[ALUOP_LSB +: ALUOP_W]   = op;
        v[RADDR_B_LSB +: ADDR_W]  = rb;
        v[RADDR_A_LSB +: ADDR_W]  = ra;
        v[WADDR_LSB +: ADDR_W]    = rw;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] v);
        tb_we = 1'b1; tb_wa = a; tb_wd = v;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Present ins until accepted; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] ins);
        int n;
        n = 0;
        while (!d_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", 32'(d_ready), 32'd1);
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Sample six negedges after accept: DECODE, EXEC, EXEC, WB, IDLE(done), IDLE.
    task automatic observe(input string tag, input logic exp_wr, input logic exp_wr_n);
        int wr_n, wr_i, dn_n, dn_i, nw_n;
        wr_n = 0; wr_i = 0; dn_n = 0; dn_i = 0; nw_n = 0;
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) @(negedge clk);
            if (i == 1) check({tag, "_ready_busy"}, {30'd0, d_ready, d_busy}, 32'd1);
            if (d_wr)   begin wr_n++; wr_i = i; end
            if (d_done) begin dn_n++; dn_i = i; end
            if (n_wr)   nw_n++;
        end
        check({tag, "_wr_count"}, 32'(wr_n), 32'(exp_wr));
        if (exp_wr) check({tag, "_wr_cycle"}, 32'(wr_i), 32'd4);
        check({tag, "_done_count"}, 32'(dn_n), 32'd1);
        check({tag, "_done_cycle"}, 32'(dn_i), 32'd5);
        check({tag, "_nr0_wr_count"}, 32'(nw_n), 32'(exp_wr_n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] list [3];
        int acc [3];
        int idx, cyc, rdy_low, wr_seen;

        rst = 1'b1; instr = '0; instr_valid = 1'b0;
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        #1;
        check("rst_ctrl", d_ctrl, 32'd0);
        check("rst_flags", {28'd0, d_wr, d_zf, d_of, d_done}, 32'd0);
        check("rst_cnt", 32'(d_cnt), 32'd0);
        check("rst_ready_busy", {30'd0, d_ready, d_busy}, 32'd2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single add r3 = r1 + r2
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        preload(5'd3, 32'd0);
        send(mk(4'h1, 5'd2, 5'd1, 5'd3));
        check("t1_ctrl", d_ctrl, 32'h10200403);
        observe("t1", 1'b1, 1'b1);
        exp_cnt++;
        check("t1_r3", rf[3], 32'd12);
        check("t1_zf", 32'(d_zf), 32'd0);
        check("t1_cnt", 32'(d_cnt), 32'(exp_cnt));
        check("t1_ctrl_hold", d_ctrl, 32'h10200403);

        // 2: overflow, then zero
        preload(5'd1, 32'h7FFFFFFF);
        preload(5'd2, 32'd1);
        send(mk(4'h1, 5'd2, 5'd1, 5'd4));
        observe("t2a", 1'b1, 1'b1);
        exp_cnt++;
        check("t2a_of", 32'(d_of), 32'd1);
        check("t2a_zf", 32'(d_zf), 32'd0);
        check("t2a_r4", rf[4], 32'h80000000);
        preload(5'd5, 32'd3);
        preload(5'd6, 32'hFFFFFFFD);
        send(mk(4'h1, 5'd6, 5'd5, 5'd7));
        observe("t2b", 1'b1, 1'b1);
        exp_cnt++;
        check("t2b_zf", 32'(d_zf), 32'd1);
        check("t2b_of", 32'(d_of), 32'd0);
        check("t2b_r7", rf[7], 32'd0);

        // 3: back-to-back with instr_valid held high
        list[0] = mk(4'h1, 5'd2, 5'd1, 5'd8);   // r8  = 7FFFFFFF + 1
        list[1] = mk(4'h1, 5'd1, 5'd8, 5'd9);   // r9  = r8 + 7FFFFFFF
        list[2] = mk(4'h1, 5'd2, 5'd9, 5'd10);  // r10 = r9 + 1
        idx = 0; cyc = 0; rdy_low = 0;
        while (cyc < 60) begin
            if (d_ready) begin
                if (idx < 3) begin
                    instr = list[idx];
                    instr_valid = 1'b1;
                    acc[idx] = cyc;
                    idx++;
                end else begin
                    instr_valid = 1'b0;
                    break;
                end
            end else begin
                rdy_low++;
            end
            @(negedge clk);
            cyc++;
        end
        instr_valid = 1'b0;
        exp_cnt += 3;
        check("t3_accepts", 32'(idx), 32'd3);
        check("t3_gap01", 32'(acc[1] - acc[0]), 32'd5);
        check("t3_gap12", 32'(acc[2] - acc[1]), 32'd5);
        check("t3_ready_low", 32'(rdy_low), 32'd12);
        check("t3_done", 32'(d_done), 32'd1);
        check("t3_cnt", 32'(d_cnt), 32'(exp_cnt));
        check("t3_r9", rf[9], 32'hFFFFFFFF);
        check("t3_r10", rf[10], 32'd0);
        check("t3_zf", 32'(d_zf), 32'd1);
        @(negedge clk);

        // 4: write to r0
        send(mk(4'h1, 5'd2, 5'd1, 5'd0));
        observe("t4", 1'b0, 1'b1);
        exp_cnt++;
        check("t4_cnt", 32'(d_cnt), 32'(exp_cnt));
        check("t4_nr0_cnt", 32'(n_cnt), 32'(exp_cnt));

        // 5: asynchronous reset during EXEC
        preload(5'd11, 32'h0000A5A5);
        send(mk(4'h1, 5'd2, 5'd1, 5'd11));
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("t5_busy", 32'(d_busy), 32'd0);
        check("t5_ready", 32'(d_ready), 32'd1);
        check("t5_ctrl", d_ctrl, 32'd0);
        check("t5_cnt", 32'(d_cnt), 32'd0);
        check("t5_wr_done", {30'd0, d_wr, d_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (d_wr) wr_seen++;
            @(negedge clk);
        end
        exp_cnt = 0;
        check("t5_no_write", 32'(wr_seen), 32'd0);
        check("t5_r11", rf[11], 32'h0000A5A5);
        check("t5_cnt_after", 32'(d_cnt), 32'd0);

        // 6: masking and 2-bit counter wrap
        send(32'hFFFFFFFF);
        check("t6_mask", d_ctrl, 32'hF1F07C1F);
        observe("t6a", 1'b1, 1'b1);
        exp_cnt++;
        for (int k = 0; k < 4; k++) begin
            send(mk(4'h1, 5'd2, 5'd1, 5'd12));
            observe("t6b", 1'b1, 1'b1);
            exp_cnt++;
        end
        check("t6_cnt", 32'(d_cnt), 32'(exp_cnt));
        check("t6_w2_cnt", 32'(q_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
